// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame buffer SRAM arbiter.
package fb_arb_pkg;

    localparam int unsigned DEF_ADR_W    = 16;
    localparam int unsigned DEF_DAT_W    = 8;
    localparam int unsigned Pixels_Frame = 38400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        TURN  = 2'd3
    } fbState_e;

endpackage

// File: rtl/frame_buffer_arbiter_rd_tag_pipe.sv
// Read-tag pipe: one valid bit per issued read, aged RD_LAT clocks so the top
// knows on which edge the SRAM read data must be sampled.
module rd_tag_pipe #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic iClk100,
    input  logic iRst_n,
    input  logic iIssue,
    output logic oStrobe
);

    logic [RD_LAT-1:0] tagPipe;

    if (RD_LAT == 1) begin : gSingle
        always_ff @(posedge iClk100 or negedge iRst_n) begin
            if (!iRst_n) begin
                tagPipe <= '0;
            end else begin
                tagPipe <= iIssue;
            end
        end
    end else begin : gShift
        always_ff @(posedge iClk100 or negedge iRst_n) begin
            if (!iRst_n) begin
                tagPipe <= '0;
            end else begin
                tagPipe <= {tagPipe[RD_LAT-2:0], iIssue};
            end
        end
    end

    // High on the cycle before the edge at which the read data is due.
    assign oStrobe = tagPipe[RD_LAT-1];

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port pixel SRAM arbiter: LCD scan-out reads with deadline priority,
// pixel-loader writes through req/ack, write->read turnaround and data return.
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADR_W     = DEF_ADR_W,
    parameter int unsigned DAT_W     = DEF_DAT_W,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_STARVE = 8
) (
    input  logic             iClk100,
    input  logic             iRst_n,
    input  logic             iDispReq,
    input  logic [ADR_W-1:0] iDispAdr,
    output logic [DAT_W-1:0] oDispData,
    output logic             oDispValid,
    input  logic             iWrReq,
    input  logic [ADR_W-1:0] iWrAdr,
    input  logic [DAT_W-1:0] iWrData,
    output logic             oWrAck,
    output logic             oMemCe,
    output logic             oMemWe,
    output logic [ADR_W-1:0] oMemAdr,
    output logic [DAT_W-1:0] oMemWrData,
    input  logic [DAT_W-1:0] iMemRdData,
    output logic [7:0]       oMissCnt
);

    localparam int unsigned      STV_W   = $clog2(WR_STARVE + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(WR_STARVE);

    fbState_e         fsmState;
    fbState_e         fsmNext;
    logic             pendValid;
    logic [ADR_W-1:0] pendAdr;
    logic [STV_W-1:0] starveCnt;
    logic             dispAny;
    logic             starved;
    logic             pickRead;
    logic             pickWrite;
    logic             issueRead;
    logic             issueWrite;
    logic [ADR_W-1:0] rdAdr;
    logic             rdStrobe;

    assign dispAny = iDispReq | pendValid;
    assign rdAdr   = pendValid ? pendAdr : iDispAdr;
    assign starved = (starveCnt >= STV_MAX);

    always_comb begin
        pickRead  = 1'b0;
        pickWrite = 1'b0;
        if (dispAny && !starved) begin
            pickRead = 1'b1;
        end else if (iWrReq) begin
            pickWrite = 1'b1;
        end else if (dispAny) begin
            pickRead = 1'b1;
        end
    end

    // A read chosen while the bus is in write mode spends this edge in TURN
    // and stays pending; it issues on the following edge.
    assign issueRead  = pickRead && (fsmState != WRITE);
    assign issueWrite = pickWrite;

    always_comb begin
        fsmNext = IDLE;
        if (issueWrite) begin
            fsmNext = WRITE;
        end else if (issueRead) begin
            fsmNext = READ;
        end else if (pickRead) begin
            fsmNext = TURN;
        end
    end

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            fsmState <= IDLE;
        end else begin
            fsmState <= fsmNext;
        end
    end

    // An issued pending slot frees up for a same-edge request; an unissued one
    // is overwritten by the newer request and counted as a miss.
    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            pendValid <= 1'b0;
            pendAdr   <= '0;
            oMissCnt  <= '0;
        end else if (issueRead) begin
            if (pendValid && iDispReq) begin
                pendValid <= 1'b1;
                pendAdr   <= iDispAdr;
            end else begin
                pendValid <= 1'b0;
            end
        end else if (iDispReq) begin
            pendValid <= 1'b1;
            pendAdr   <= iDispAdr;
            if (pendValid && (oMissCnt != 8'hFF)) begin
                oMissCnt <= oMissCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            starveCnt <= '0;
        end else if (issueWrite || !iWrReq) begin
            starveCnt <= '0;
        end else if (!starved) begin
            starveCnt <= starveCnt + STV_W'(1);
        end
    end

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            oMemCe     <= 1'b0;
            oMemWe     <= 1'b0;
            oMemAdr    <= '0;
            oMemWrData <= '0;
            oWrAck     <= 1'b0;
        end else begin
            oMemCe <= issueRead | issueWrite;
            oMemWe <= issueWrite;
            oWrAck <= issueWrite;
            if (issueWrite) begin
                oMemAdr    <= iWrAdr;
                oMemWrData <= iWrData;
            end else if (issueRead) begin
                oMemAdr <= rdAdr;
            end
        end
    end

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) uTagPipe (
        .iClk100(iClk100),
        .iRst_n (iRst_n),
        .iIssue (issueRead),
        .oStrobe(rdStrobe)
    );

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            oDispValid <= 1'b0;
            oDispData  <= '0;
        end else begin
            oDispValid <= rdStrobe;
            if (rdStrobe) begin
                oDispData <= iMemRdData;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter with a behavioural SRAM model.
module tb_frame_buffer_arbiter;
    import fb_arb_pkg::*;

    localparam int unsigned ADR_W     = 16;
    localparam int unsigned DAT_W     = 8;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned WR_STARVE = 8;

    logic             iClk100    = 1'b0;
    logic             iRst_n     = 1'b0;
    logic             iDispReq   = 1'b0;
    logic [ADR_W-1:0] iDispAdr   = '0;
    logic [DAT_W-1:0] oDispData;
    logic             oDispValid;
    logic             iWrReq     = 1'b0;
    logic [ADR_W-1:0] iWrAdr     = '0;
    logic [DAT_W-1:0] iWrData    = '0;
    logic             oWrAck;
    logic             oMemCe;
    logic             oMemWe;
    logic [ADR_W-1:0] oMemAdr;
    logic [DAT_W-1:0] oMemWrData;
    logic [DAT_W-1:0] iMemRdData = '0;
    logic [7:0]       oMissCnt;

    int nCompared = 0;
    int nMismatch = 0;
    bit sbOn      = 1'b1;
    bit sweepDone = 1'b0;

    logic [DAT_W-1:0] sram   [0:65535];
    logic [DAT_W-1:0] refMem [0:65535];
    logic [DAT_W-1:0] expQ   [$];
    logic             histRd  [0:RD_LAT-1] = '{default: 1'b0};
    logic [ADR_W-1:0] histAdr [0:RD_LAT-1] = '{default: '0};

    always #5 iClk100 = ~iClk100;

    frame_buffer_arbiter #(
        .ADR_W    (ADR_W),
        .DAT_W    (DAT_W),
        .RD_LAT   (RD_LAT),
        .WR_STARVE(WR_STARVE)
    ) dut (
        .iClk100   (iClk100),
        .iRst_n    (iRst_n),
        .iDispReq  (iDispReq),
        .iDispAdr  (iDispAdr),
        .oDispData (oDispData),
        .oDispValid(oDispValid),
        .iWrReq    (iWrReq),
        .iWrAdr    (iWrAdr),
        .iWrData   (iWrData),
        .oWrAck    (oWrAck),
        .oMemCe    (oMemCe),
        .oMemWe    (oMemWe),
        .oMemAdr   (oMemAdr),
        .oMemWrData(oMemWrData),
        .iMemRdData(iMemRdData),
        .oMissCnt  (oMissCnt)
    );

    function automatic logic [7:0] pix(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk100);
        #1;
    endtask

    // SRAM: command seen after edge E drives data that is stable for edge E+RD_LAT.
    always @(negedge iClk100) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            histRd[i]  = histRd[i-1];
            histAdr[i] = histAdr[i-1];
        end
        histRd[0]  = oMemCe && !oMemWe;
        histAdr[0] = oMemAdr;
        if (oMemCe && oMemWe) sram[oMemAdr] = oMemWrData;
        iMemRdData = histRd[RD_LAT-1] ? sram[histAdr[RD_LAT-1]] : 8'h00;
    end

    always @(negedge iClk100) begin
        if (sbOn && oDispValid) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedValid", 64'(oDispValid), 0);
            end else begin
                checkVal("rdData", 64'(oDispData), 64'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [ADR_W-1:0] a;
        int               waitCnt;

        for (int i = 0; i < 65536; i++) begin
            sram[i]   = pix(16'(i));
            refMem[i] = pix(16'(i));
        end
        repeat (3) @(posedge iClk100);
        #1 iRst_n = 1'b1;
        checkVal("rstOut", 64'({oMemCe, oMemWe, oWrAck, oDispValid, oMemAdr,
                                oMemWrData, oDispData, oMissCnt}), 0);
        checkVal("rstFsm", 64'(dut.fsmState), 64'(IDLE));

        // single display read, RD_LAT latency
        iDispReq = 1'b1;
        iDispAdr = 16'h0010;
        expQ.push_back(refMem[16'h0010]);
        tick();
        iDispReq = 1'b0;
        checkVal("t1Ce", 64'(oMemCe), 1);
        checkVal("t1We", 64'(oMemWe), 0);
        checkVal("t1Adr", 64'(oMemAdr), 16'h0010);
        tick();
        checkVal("t1Early", 64'(oDispValid), 0);
        tick();
        checkVal("t1Valid", 64'(oDispValid), 1);
        checkVal("t1Data", 64'(oDispData), 8'hA5);
        checkVal("t1Miss", 64'(oMissCnt), 0);
        repeat (2) tick();

        // read beats write, then write, then TURN before the next read
        iWrReq   = 1'b1;
        iWrAdr   = 16'h1234;
        iWrData  = 8'h5A;
        iDispReq = 1'b1;
        iDispAdr = 16'h0020;
        expQ.push_back(refMem[16'h0020]);
        tick();
        iDispReq = 1'b0;
        checkVal("t2RdCe", 64'(oMemCe), 1);
        checkVal("t2RdWe", 64'(oMemWe), 0);
        checkVal("t2RdAdr", 64'(oMemAdr), 16'h0020);
        checkVal("t2NoAck", 64'(oWrAck), 0);
        tick();
        checkVal("t2WrCmd", 64'({oMemCe, oMemWe, oMemAdr, oMemWrData}), {2'b11, 16'h1234, 8'h5A});
        checkVal("t2Ack", 64'(oWrAck), 1);
        refMem[16'h1234] = 8'h5A;
        iWrReq   = 1'b0;
        iDispReq = 1'b1;
        iDispAdr = 16'h1234;
        expQ.push_back(refMem[16'h1234]);
        tick();
        iDispReq = 1'b0;
        checkVal("t2TurnCe", 64'(oMemCe), 0);
        checkVal("t2TurnFsm", 64'(dut.fsmState), 64'(TURN));
        tick();
        checkVal("t2RdAfterWr", 64'({oMemCe, oMemWe, oMemAdr}), {2'b10, 16'h1234});
        repeat (4) tick();

        // continuous write + display: writes win at k=8 and k=17
        iWrReq  = 1'b1;
        iWrAdr  = 16'hC000;
        iWrData = 8'h00;
        for (int k = 0; k < 20; k++) begin
            iDispReq = 1'b1;
            iDispAdr = 16'h0100 + 16'(k);
            if (!(k == 8 || k == 16 || k == 17)) expQ.push_back(refMem[16'h0100 + 16'(k)]);
            tick();
            checkVal($sformatf("t3Ack%0d", k), 64'(oWrAck), (k == 8 || k == 17) ? 1 : 0);
            if (k == 9 || k == 18) checkVal($sformatf("t3Turn%0d", k), 64'(oMemCe), 0);
            if (k == 9) checkVal("t3Miss1", 64'(oMissCnt), 1);
            if (k == 8 || k == 17) begin
                refMem[iWrAdr] = iWrData;
                iWrAdr  = iWrAdr + 16'd1;
                iWrData = iWrData + 8'd1;
            end
        end
        iDispReq = 1'b0;
        iWrReq   = 1'b0;
        checkVal("t3Miss", 64'(oMissCnt), 3);
        repeat (6) tick();
        checkVal("t3Drained", 64'(expQ.size()), 0);

        // miss counter saturation
        sbOn    = 1'b0;
        iWrReq  = 1'b1;
        iWrAdr  = 16'hC100;
        iWrData = 8'h77;
        refMem[16'hC100] = 8'h77;
        for (int k = 0; k < 1500; k++) begin
            iDispReq = 1'b1;
            iDispAdr = 16'h0200 + 16'(k);
            tick();
        end
        iDispReq = 1'b0;
        iWrReq   = 1'b0;
        repeat (6) tick();
        checkVal("t4Sat", 64'(oMissCnt), 255);
        sbOn = 1'b1;

        // reset one clock after a read issues
        iDispReq = 1'b1;
        iDispAdr = 16'h0042;
        tick();
        iDispReq = 1'b0;
        checkVal("t5Issue", 64'(oMemCe), 1);
        tick();
        iRst_n = 1'b0;
        #1;
        checkVal("t5RstOut", 64'({oMemCe, oMemWe, oWrAck, oDispValid, oMemAdr,
                                  oMemWrData, oDispData, oMissCnt}), 0);
        repeat (2) tick();
        iRst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkVal("t5NoValid", 64'(oDispValid), 0);
        end
        checkVal("t5Fsm", 64'(dut.fsmState), 64'(IDLE));

        // frame sweep with random writer traffic outside the frame
        fork
            begin : dispDrv
                for (int i = 0; i <= 396; i++) begin
                    a = (i == 396) ? 16'(Pixels_Frame - 1) : 16'(i * 97);
                    iDispReq = 1'b1;
                    iDispAdr = a;
                    expQ.push_back(refMem[a]);
                    tick();
                    iDispReq = 1'b0;
                    repeat (24) tick();
                end
                sweepDone = 1'b1;
            end
            begin : wrDrv
                while (!sweepDone) begin
                    repeat ($urandom_range(0, 12)) tick();
                    iWrReq  = 1'b1;
                    iWrAdr  = 16'hC000 | 16'($urandom_range(0, 4095));
                    iWrData = 8'($urandom);
                    waitCnt = 0;
                    do begin
                        tick();
                        waitCnt++;
                    end while (!oWrAck && waitCnt < 20);
                    checkVal("t6WrAck", 64'(oWrAck), 1);
                    refMem[iWrAdr] = iWrData;
                    iWrReq = 1'b0;
                end
            end
        join
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkVal("t6Drain", 64'(expQ.size()), 0);
        checkVal("t6Miss", 64'(oMissCnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
